// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit/control inputs and multiplexed display outputs of the scan driver
interface seg7_scan_driver_if;
  logic [15:0] digit_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [7:0]  seg7;
  logic [3:0]  line;
  logic        frame_tick;
  modport master (output digit_in, dp_in, blink_mask, lz_en, input seg7, line, frame_tick);
  modport slave  (input digit_in, dp_in, blink_mask, lz_en, output seg7, line, frame_tick);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes four BCD digits onto one 7-segment bus with frame-atomic capture, LZ blanking and blink
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input logic clk0,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_n;
  logic [FW-1:0] fc;
  logic          phase, phase_n;
  logic [15:0]   sh_d, d_n;
  logic [3:0]    sh_dp, sh_bm, dp_n, bm_n, lzb, dig;
  logic          sh_lz, lz_n;
  logic          scan_tick, wrap, fc_wrap;
  logic [6:0]    seg;
  logic [7:0]    seg7_n;
  // Next-slot view: on a frame wrap the freshly captured inputs and blink phase feed digit 0 directly
  always_comb begin
    scan_tick = cnt == CW'(SCAN_DIV - 1);
    wrap      = scan_tick && idx == 2'd3;
    fc_wrap   = wrap && fc == FW'(BLINK_FRAMES - 1);
    idx_n     = idx + 2'd1;
    d_n       = wrap ? bus.digit_in : sh_d;
    dp_n      = wrap ? bus.dp_in : sh_dp;
    bm_n      = wrap ? bus.blink_mask : sh_bm;
    lz_n      = wrap ? bus.lz_en : sh_lz;
    phase_n   = phase ^ fc_wrap;
    dig       = d_n[{idx_n, 2'b00} +: 4];
    lzb[3]    = lz_n && d_n[15:12] == 4'd0;
    lzb[2]    = lzb[3] && d_n[11:8] == 4'd0;
    lzb[1]    = lzb[2] && d_n[7:4] == 4'd0;
    lzb[0]    = 1'b0;
    case (dig)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0100111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    seg7_n = (phase_n && bm_n[idx_n]) ? 8'h00 : {dp_n[idx_n], lzb[idx_n] ? 7'h00 : seg};
  end
  // Prescaler, digit scan, frame capture, blink timing and registered display outputs
  always_ff @(posedge clk0) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= 2'd0;
      fc             <= '0;
      phase          <= 1'b0;
      sh_d           <= 16'h0;
      sh_dp          <= 4'h0;
      sh_bm          <= 4'h0;
      sh_lz          <= 1'b0;
      bus.seg7       <= 8'h00;
      bus.line       <= 4'b0001;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= scan_tick ? '0 : cnt + 1'b1;
      bus.frame_tick <= wrap;
      if (scan_tick) begin
        idx      <= idx_n;
        bus.line <= 4'b0001 << idx_n;
        bus.seg7 <= seg7_n;
      end
      if (wrap) begin
        sh_d  <= bus.digit_in;
        sh_dp <= bus.dp_in;
        sh_bm <= bus.blink_mask;
        sh_lz <= bus.lz_en;
        fc    <= fc_wrap ? '0 : fc + 1'b1;
        phase <= phase_n;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard check of the scan driver against a slot/frame reference model
module tb_seg7_scan_driver;
  localparam int SD = 4;
  localparam int BF = 2;
  logic clk0 = 1'b0;
  logic rst;
  int compared = 0;
  int mismatched = 0;
  logic [12:0] q[$];
  logic [6:0] seg_tbl [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0100111, 7'b1111111, 7'b1101111};
  seg7_scan_driver_if bus ();
  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (.clk0(clk0), .rst(rst), .bus(bus));
  always #5 clk0 = ~clk0;
  function automatic logic [7:0] ref_seg(logic [15:0] d, logic [3:0] dp, logic [3:0] bm, logic lz, int slot, int phase);
    logic [3:0] v;
    logic blank;
    v = d[slot*4 +: 4];
    if (phase != 0 && bm[slot]) return 8'h00;
    blank = lz && slot > 0;
    for (int j = slot; j < 4; j++) if (d[j*4 +: 4] != 4'd0) blank = 1'b0;
    return {dp[slot], blank ? 7'h00 : (v < 10 ? seg_tbl[v] : 7'h00)};
  endfunction
  // Reference model: slot k = n/SD after n run cycles; frame f = k/4 captures inputs at its start, blinks when (f/BF) is odd
  initial begin
    int n, k, slot;
    bit started, ft;
    logic [15:0] m_d;
    logic [3:0] m_dp, m_bm;
    logic m_lz;
    logic [7:0] s;
    started = 0;
    n = 0;
    forever begin
      @(posedge clk0);
      if (rst) begin
        started = 1;
        n = 0;
        m_d = 0; m_dp = 0; m_bm = 0; m_lz = 0;
        q.push_back({4'b0001, 8'h00, 1'b0});
      end else if (started) begin
        n++;
        k = n / SD;
        slot = k % 4;
        ft = (n % SD == 0) && slot == 0;
        if (ft) begin
          m_d = bus.digit_in; m_dp = bus.dp_in; m_bm = bus.blink_mask; m_lz = bus.lz_en;
        end
        s = (k == 0) ? 8'h00 : ref_seg(m_d, m_dp, m_bm, m_lz, slot, (k / 4 / BF) % 2);
        q.push_back({4'b0001 << slot, s, ft});
      end
    end
  end
  // Monitor: the DUT presents a display state every cycle; compare it against the oldest expectation
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk0);
      if (q.size() > 0) begin
        e = q.pop_front();
        compared++;
        if ({bus.line, bus.seg7, bus.frame_tick} !== e) begin
          mismatched++;
          $display("FAIL display @%0t: got line=%b seg7=%h ft=%b, want line=%b seg7=%h ft=%b",
                   $time, bus.line, bus.seg7, bus.frame_tick, e[12:9], e[8:1], e[0]);
        end
      end
    end
  end
  task automatic cyc(int c);
    repeat (c) @(negedge clk0);
  endtask
  task automatic setin(logic [15:0] d, logic [3:0] dp, logic [3:0] bm, logic lz);
    bus.digit_in = d; bus.dp_in = dp; bus.blink_mask = bm; bus.lz_en = lz;
  endtask
  task automatic do_reset(int c);
    rst = 1'b1;
    cyc(c);
    rst = 1'b0;
  endtask
  // Stimulus: directed scenarios followed by random inputs changing at random times with occasional resets
  initial begin
    logic [15:0] d;
    rst = 1'b1;
    setin(16'h2359, 4'h0, 4'h0, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(3 * 4 * SD);
    setin(16'h1234, 4'h0, 4'h0, 1'b0);
    do_reset(1);
    cyc(4 * SD + SD + 1);
    setin(16'h5678, 4'h0, 4'h0, 1'b0);
    cyc(2 * 4 * SD);
    setin(16'h0005, 4'b0100, 4'h0, 1'b1);
    cyc(3 * 4 * SD);
    setin(16'h000A, 4'b0001, 4'b0001, 1'b0);
    cyc(10 * 4 * SD);
    do_reset(1);
    cyc(2 * SD + 1);
    do_reset(1);
    cyc(40);
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int j = 0; j < 4; j++) d[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        setin(d, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 1'($urandom));
      end
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
      else cyc(1);
    end
    cyc(2);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
